// File: rtl/adder_sum_decoder_if.sv
// Handshake bundle for adder_sum_decoder: operand set in, recovered operand out.
interface adder_sum_decoder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_total;
    logic [WIDTH-1:0] in_a;
    logic             in_ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_b;
    logic             out_err;

    // Producer/consumer side (testbench or upstream capture logic)
    modport master (
        output in_valid, in_total, in_a, in_ci, out_ready,
        input  in_ready, out_valid, out_b, out_err
    );

    // Decoder side
    modport slave (
        input  in_valid, in_total, in_a, in_ci, out_ready,
        output in_ready, out_valid, out_b, out_err
    );
endinterface

// File: rtl/adder_sum_decoder.sv
// Bit-serial inverse of the ripple adder: recovers b = {co,sum} - a - ci,
// one difference bit per clock (LSB first), and flags totals that no
// WIDTH-bit b could have produced.
module adder_sum_decoder #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    adder_sum_decoder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;

    logic [WIDTH:0]   t_r;        // total, shifted right one bit per CALC edge
    logic [WIDTH:0]   a_r;        // zero-extended known operand, shifted alongside
    logic [WIDTH-1:0] d_r;        // difference bits collected so far, filled from the top
    logic             bw_r;       // running borrow, seeded with the adder carry-in
    logic [CW-1:0]    cnt_r;      // index of the bit being produced

    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_b_r;
    logic             out_err_r;

    logic             d_bit_s;
    logic             bw_s;
    logic [WIDTH:0]   d_full_s;
    logic             last_s;

    // Full-subtractor cell: returns {borrow_out, difference} for t - a - bw.
    function automatic logic [1:0] sub_bit(input logic t, input logic a, input logic bw);
        logic d;
        logic b;
        d = t ^ a ^ bw;
        b = (~t & a) | (~t & bw) | (a & bw);
        return {b, d};
    endfunction

    // Current subtractor bit and the difference word as it will look after this edge.
    always_comb begin
        {bw_s, d_bit_s} = sub_bit(t_r[0], a_r[0], bw_r);
        d_full_s        = {d_bit_s, d_r};
        last_s          = (cnt_r == CW'(WIDTH));
    end

    // Next-state logic for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_s = CALC;
                else              state_s = IDLE;
            end
            CALC: begin
                if (last_s) state_s = DONE;
                else        state_s = CALC;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register; a reset mid-operation discards the work in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Handshake flags follow the state being entered so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Operand capture, serial subtraction and result latching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_r       <= {(WIDTH+1){1'b0}};
            a_r       <= {(WIDTH+1){1'b0}};
            d_r       <= {WIDTH{1'b0}};
            bw_r      <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            out_b_r   <= {WIDTH{1'b0}};
            out_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        t_r   <= bus.in_total;
                        a_r   <= {1'b0, bus.in_a};
                        bw_r  <= bus.in_ci;
                        d_r   <= {WIDTH{1'b0}};
                        cnt_r <= {CW{1'b0}};
                    end
                end
                CALC: begin
                    t_r   <= {1'b0, t_r[WIDTH:1]};
                    a_r   <= {1'b0, a_r[WIDTH:1]};
                    d_r   <= d_full_s[WIDTH:1];
                    bw_r  <= bw_s;
                    cnt_r <= cnt_r + CW'(1);
                    // Top bit set or a borrow left over means b does not fit in WIDTH bits.
                    if (last_s) begin
                        out_b_r   <= d_full_s[WIDTH-1:0];
                        out_err_r <= bw_s | d_full_s[WIDTH];
                    end
                end
                DONE: begin
                    out_b_r   <= out_b_r;
                    out_err_r <= out_err_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_b     = out_b_r;
    assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_adder_sum_decoder.sv
// Self-checking bench for adder_sum_decoder (WIDTH=4): directed vectors,
// randomized traffic against an arithmetic model, backpressure, back-to-back
// and reset-abort scenarios.
module tb_adder_sum_decoder;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    adder_sum_decoder_if #(.WIDTH(W)) bus ();

    adder_sum_decoder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: b is the true difference reduced mod 2^W; error when it is out of range.
    function automatic void model(input logic [W:0] total, input logic [W-1:0] a, input logic ci,
                                  output logic [W-1:0] b, output logic err);
        int diff;
        diff = int'(total) - int'(a) - int'(ci);
        err  = (diff < 0) || (diff > (1 << W) - 1);
        b    = W'(((diff % (1 << W)) + (1 << W)) % (1 << W));
    endfunction

    // Runs one operation from a negedge; returns observations, ends at a negedge.
    task automatic do_op(input logic [W:0] total, input logic [W-1:0] a, input logic ci,
                         input int hold, output logic [W-1:0] b, output logic err,
                         output int lat, output bit stable, output bit released, output bit accepted);
        bit seen;
        accepted     = (bus.in_ready === 1'b1);
        bus.in_valid = 1'b1;
        bus.in_total = total;
        bus.in_a     = a;
        bus.in_ci    = ci;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        stable = 1'b1;
        seen   = 1'b0;
        lat    = 0;
        while (!seen && lat < 20) begin
            // Operands are garbage from here on and must not affect the result.
            bus.in_total = 5'($urandom);
            bus.in_a     = 4'($urandom);
            bus.in_ci    = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.in_ready !== 1'b0) stable = 1'b0;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            lat = 99;
            b   = 4'bxxxx;
            err = 1'bx;
            released = 1'b0;
        end else begin
            b   = bus.out_b;
            err = bus.out_err;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || bus.out_b !== b || bus.out_err !== err ||
                    bus.in_ready !== 1'b0) stable = 1'b0;
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
            released = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_total  = 5'd0;
        bus.in_a      = 4'd0;
        bus.in_ci     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_b, bus.out_err} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b b=%h err=%b want rdy=1 vld=0 b=0 err=0",
                     bus.in_ready, bus.out_valid, bus.out_b, bus.out_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W:0]   tt [5] = '{5'h0F, 5'h1F, 5'h03, 5'h10, 5'h00};
        logic [W-1:0] aa [5] = '{4'd5, 4'd15, 4'd5, 4'd0, 4'd15};
        logic         cc [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] eb [5] = '{4'd9, 4'd15, 4'd14, 4'd0, 4'd0};
        logic         ee [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] b;
        logic         err;
        int           lat;
        bit           st, rel, acc;
        for (int i = 0; i < 5; i++) begin
            do_op(tt[i], aa[i], cc[i], 0, b, err, lat, st, rel, acc);
            n_checks++;
            if (b !== eb[i] || err !== ee[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got b=%h err=%b want b=%h err=%b", i, b, err, eb[i], ee[i]);
            end
            n_checks++;
            if (lat !== W + 1 || !acc || !rel) begin
                n_fail++;
                $display("FAIL directed_latency_%0d: got lat=%0d acc=%b rel=%b want lat=%0d acc=1 rel=1",
                         i, lat, acc, rel, W + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [W:0]   t;
        logic [W-1:0] a, b, eb;
        logic         c, err, ee;
        int           lat;
        bit           st, rel, acc;
        for (int i = 0; i < 40; i++) begin
            t = 5'($urandom);
            a = 4'($urandom);
            c = 1'($urandom);
            model(t, a, c, eb, ee);
            do_op(t, a, c, $urandom_range(0, 3), b, err, lat, st, rel, acc);
            n_checks++;
            if (b !== eb || err !== ee || lat !== W + 1 || !st || !rel) begin
                n_fail++;
                $display("FAIL random_%0d t=%h a=%h ci=%b: got b=%h err=%b lat=%0d st=%b rel=%b want b=%h err=%b lat=%0d",
                         i, t, a, c, b, err, lat, st, rel, eb, ee, W + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] b;
        logic         err;
        int           lat;
        bit           st, rel, acc;
        do_op(5'h03, 4'd5, 1'b0, 7, b, err, lat, st, rel, acc);
        n_checks++;
        if (!st || !rel || b !== 4'd14 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure: got stable=%b released=%b b=%h err=%b want stable=1 released=1 b=e err=1",
                     st, rel, b, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eb;
        logic         ee;
        int           gap, lat;
        bit           seen;
        // First op; in_valid for the next one is raised while the first result is still pending.
        bus.in_valid = 1'b1; bus.in_total = 5'h0F; bus.in_a = 4'd5; bus.in_ci = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_total = 5'h1A; bus.in_a = 4'd3; bus.in_ci = 1'b0;
        gap = 1;
        seen = 1'b0;
        while (!seen && gap < 20) begin
            @(posedge clk); gap++; @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); gap++; @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_overlap: got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        n_checks++;
        if (gap !== W + 3) begin
            n_fail++;
            $display("FAIL initiation_interval: got %0d want %0d", gap, W + 3);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a = 4'd9;
        model(5'h1A, 4'd3, 1'b0, eb, ee);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (lat !== W + 1 || bus.out_b !== eb || bus.out_err !== ee) begin
            n_fail++;
            $display("FAIL back_to_back_second: got lat=%0d b=%h err=%b want lat=%0d b=%h err=%b",
                     lat, bus.out_b, bus.out_err, W + 1, eb, ee);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic [W-1:0] b;
        logic         err;
        int           lat;
        bit           st, rel, acc, leak;
        do_op(5'h0F, 4'd5, 1'b1, 0, b, err, lat, st, rel, acc);
        bus.in_valid = 1'b1; bus.in_total = 5'h03; bus.in_a = 4'd5; bus.in_ci = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_b, bus.out_err} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_calc: got rdy=%b vld=%b b=%h err=%b want rdy=1 vld=0 b=0 err=0",
                     bus.in_ready, bus.out_valid, bus.out_b, bus.out_err);
        end
        @(negedge clk);
        rst = 1'b0;
        leak = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) leak = 1'b1;
        end
        n_checks++;
        if (leak) begin
            n_fail++;
            $display("FAIL aborted_op_output: got leak=1 want leak=0");
        end
        do_op(5'h1F, 4'd15, 1'b1, 1, b, err, lat, st, rel, acc);
        n_checks++;
        if (b !== 4'd15 || err !== 1'b0 || lat !== W + 1) begin
            n_fail++;
            $display("FAIL after_reset_op: got b=%h err=%b lat=%0d want b=f err=0 lat=%0d", b, err, lat, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_sum_decoder.md
Name: adder_sum_decoder

Overview:
- Inverse of the 4-bit ripple adder family: takes a registered adder result {co,sum}, one known operand a, and the carry-in ci, and recovers the other operand b = {co,sum} - a - ci.
- Sits on the check/readback side of the adder delay-model test structures. It reconstructs operands from captured adder outputs and flags results that no WIDTH-bit b could have produced.
- Bit-serial, one result bit per clock, with valid/ready handshakes on input and output.

Parameters:
- WIDTH, 4, operand width; total input is WIDTH+1 bits ({co,sum}).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set on in_total/in_a/in_ci is valid
- in_ready  output  1  block can accept an operand set
- in_total  input  WIDTH+1  adder result {co,sum}
- in_a  input  WIDTH  known operand a
- in_ci  input  1  carry-in used by the adder
- out_valid  output  1  out_b/out_err valid
- out_ready  input  1  consumer accepts result
- out_b  output  WIDTH  recovered operand, (in_total - in_a - in_ci) mod 2^WIDTH
- out_err  output  1  1 = no valid WIDTH-bit b exists (difference negative or > 2^WIDTH-1)

Behaviour:
- Reset (async, active-high):
  - state=IDLE; in_ready=1; out_valid=0; out_b=0; out_err=0; internal shift regs, bit counter and borrow cleared.
  - Reset asserted mid-CALC or in DONE aborts the operation; no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_total, zero-extended in_a, in_ci (as initial borrow); counter=0; go to CALC.
  - in_ready drops the cycle after acceptance.
- CALC:
  - in_ready=0, out_valid=0. One bit per edge, LSB first.
  - d[i] = t[i] ^ a[i] ^ bw.
  - bw' = (~t[i] & a[i]) | (~t[i] & bw) | (a[i] & bw).
  - counter increments each edge.
  - After bit WIDTH (i.e. WIDTH+1 edges in CALC), go to DONE.
- DONE:
  - out_valid=1.
  - out_b = d[WIDTH-1:0].
  - out_err = final borrow | d[WIDTH].
- Latency:
  - Acceptance edge E0; out_valid rises at edge E0+WIDTH+1 (5 edges for WIDTH=4).
- Output handshake:
  - out_b/out_err are held stable while out_valid=1 and out_ready=0, for unbounded backpressure.
  - On an edge with out_valid=1 and out_ready=1, go to IDLE and drop out_valid.
  - out_b/out_err keep their last values until the next result; they are don't-care when out_valid=0.
- No overlap:
  - in_ready=0 in CALC and DONE, so a new operand is never accepted in the same edge as output completion.
  - Minimum initiation interval: WIDTH+3 cycles.
- Input changes while in_ready=0 are ignored; operands are sampled only at the acceptance edge.
- Arithmetic:
  - All subtraction is modulo 2^(WIDTH+1).
  - Negative true difference sets final borrow=1.
  - True difference in [2^WIDTH, 2^(WIDTH+1)-1] sets d[WIDTH]=1.
  - Either condition sets out_err.
- in_ci=1 with in_a=all-ones and in_total=0 gives a maximum-magnitude borrow: out_err=1, out_b wraps to the mod value.

Test Plan:
- Reset, then total=5'h0F, a=5, ci=1 -> out_valid 5 cycles after acceptance; out_b=9, out_err=0.
- total=5'h1F, a=15, ci=1 -> out_b=15, out_err=0 (maximum legal sum).
- Underflow: total=5'h03, a=5, ci=0 -> out_b=14 (3-5 mod 16), out_err=1.
- Overflow: total=5'h10, a=0, ci=0 -> out_b=0, out_err=1.
- Backpressure and back-to-back traffic:
  - Hold out_ready=0 for 7 cycles -> out_valid and out_b stay stable, in_ready stays 0.
  - Then pulse out_ready -> IDLE; a second operand set is accepted on the next in_valid with no overlap.
  - Change in_a during CALC -> result unaffected.
- Assert rst for 1 cycle mid-CALC (after 2 bits) -> outputs return to reset values immediately. The aborted operation yields no out_valid, and the next operation completes correctly.
